avst_stream_monitor: RTL

Passive multi-channel Avalon-ST protocol and traffic monitor for the TSE MAC receive/transmit streams. It taps N_CH streams without driving them, tracks packet framing per channel with a small FSM, latches sticky error flags, and keeps saturating packet, byte and error-packet counters. This block generalises the fixed single-stream error latches (rx error and empty-without-eop) in the top level to N channels, adds framing and length checks, and exposes per-channel statistics for LEDs and HEX displays.

---
 rtl/avst_stream_monitor.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/avst_stream_monitor.sv
// Passive N-channel Avalon-ST monitor: per-channel framing FSM, sticky error flags and
// saturating packet/byte/error-packet counters with a channel-selected readout.
module avst_stream_monitor #(
    parameter int N_CH    = 2,
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int ERR_W   = 6,
    parameter int CNT_W   = 32,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic                                      sys_clk,
    input  logic                                      core_reset_n,
    input  logic [N_CH-1:0]                           st_valid,
    input  logic [N_CH-1:0]                           st_ready,
    input  logic [N_CH-1:0]                           st_sop,
    input  logic [N_CH-1:0]                           st_eop,
    input  logic [N_CH*EMPTY_W-1:0]                   st_empty,
    input  logic [N_CH*ERR_W-1:0]                     st_error,
    input  logic                                      clear,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
    output logic [N_CH*5-1:0]                         err_flags,
    output logic                                      any_err,
    output logic [CNT_W-1:0]                          pkt_cnt,
    output logic [CNT_W-1:0]                          byte_cnt,
    output logic [CNT_W-1:0]                          err_pkt_cnt
);

    localparam int               SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int               BEAT_BYTES = DATA_W / 8;
    localparam int               SUM_W      = ((CNT_W > 16) ? CNT_W : 16) + 2;
    localparam logic [15:0]      MIN_L      = 16'(MIN_LEN);
    localparam logic [15:0]      MAX_L      = 16'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    typedef enum logic {IDLE, IN_PKT} state_t;

    logic [N_CH-1:0][CNT_W-1:0] pkt_all;
    logic [N_CH-1:0][CNT_W-1:0] byte_all;
    logic [N_CH-1:0][CNT_W-1:0] errp_all;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + b;
        return (s > SUM_W'(CNT_SAT)) ? CNT_SAT : s[CNT_W-1:0];
    endfunction

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t           state, state_nxt;
        logic [15:0]      len, len_nxt;
        logic             marker, marker_nxt;
        logic [4:0]       flags_q, flags_nxt;
        logic [CNT_W-1:0] pkt_q, pkt_nxt;
        logic [CNT_W-1:0] byte_q, byte_nxt;
        logic [CNT_W-1:0] errp_q, errp_nxt;

        logic               accepted, beat_rx_err, beat_empty_err;
        logic [EMPTY_W-1:0] beat_empty;
        logic               pkt_bad, counted, len_err;
        logic [15:0]        base_len, done_len, byte_add;
        logic [16:0]        done_sum, acc_sum;
        logic [1:0]         pkt_inc, err_inc;

        assign accepted       = st_valid[c] & st_ready[c];
        assign beat_empty     = st_empty[c*EMPTY_W +: EMPTY_W];
        assign beat_rx_err    = |st_error[c*ERR_W +: ERR_W];
        assign beat_empty_err = (beat_empty != '0) & ~st_eop[c];

        // A sop inside a packet closes the old one as an errored, zero-byte packet and then
        // falls through to the normal start-of-packet handling, so pkt_cnt can step by two.
        always_comb begin
            state_nxt  = state;
            len_nxt    = len;
            marker_nxt = marker;
            flags_nxt  = flags_q;
            pkt_inc    = '0;
            err_inc    = '0;
            byte_add   = '0;
            base_len   = '0;
            pkt_bad    = 1'b0;
            counted    = 1'b0;
            done_sum   = '0;
            done_len   = '0;
            acc_sum    = '0;
            len_err    = 1'b0;
            if (accepted) begin
                flags_nxt[0] = flags_q[0] | beat_rx_err;
                flags_nxt[1] = flags_q[1] | beat_empty_err;
                if (st_sop[c]) begin
                    if (state == IN_PKT) begin
                        flags_nxt[2] = 1'b1;
                        pkt_inc      = 2'd1;
                        err_inc      = 2'd1;
                    end
                    pkt_bad = beat_rx_err | beat_empty_err;
                    counted = 1'b1;
                end else if (state == IDLE) begin
                    flags_nxt[3] = 1'b1;
                end else begin
                    base_len = len;
                    pkt_bad  = marker | beat_rx_err | beat_empty_err;
                    counted  = 1'b1;
                end
                if (counted) begin
                    if (st_eop[c]) begin
                        done_sum     = {1'b0, base_len} + 17'(BEAT_BYTES) - 17'(beat_empty);
                        done_len     = done_sum[16] ? 16'hFFFF : done_sum[15:0];
                        len_err      = (done_len < MIN_L) || (done_len > MAX_L);
                        flags_nxt[4] = flags_q[4] | len_err;
                        pkt_inc      = pkt_inc + 2'd1;
                        if (pkt_bad | len_err) begin
                            err_inc = err_inc + 2'd1;
                        end
                        byte_add   = done_len;
                        state_nxt  = IDLE;
                        len_nxt    = '0;
                        marker_nxt = 1'b0;
                    end else begin
                        acc_sum    = {1'b0, base_len} + 17'(BEAT_BYTES);
                        len_nxt    = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
                        state_nxt  = IN_PKT;
                        marker_nxt = pkt_bad;
                    end
                end
            end
            pkt_nxt  = sat_add(pkt_q, SUM_W'(pkt_inc));
            byte_nxt = sat_add(byte_q, SUM_W'(byte_add));
            errp_nxt = sat_add(errp_q, SUM_W'(err_inc));
            if (clear) begin
                state_nxt  = IDLE;
                len_nxt    = '0;
                marker_nxt = 1'b0;
                flags_nxt  = '0;
                pkt_nxt    = '0;
                byte_nxt   = '0;
                errp_nxt   = '0;
            end
        end

        always_ff @(posedge sys_clk or negedge core_reset_n) begin
            if (!core_reset_n) begin
                state   <= IDLE;
                len     <= '0;
                marker  <= 1'b0;
                flags_q <= '0;
                pkt_q   <= '0;
                byte_q  <= '0;
                errp_q  <= '0;
            end else begin
                state   <= state_nxt;
                len     <= len_nxt;
                marker  <= marker_nxt;
                flags_q <= flags_nxt;
                pkt_q   <= pkt_nxt;
                byte_q  <= byte_nxt;
                errp_q  <= errp_nxt;
            end
        end

        assign err_flags[c*5 +: 5] = flags_q;
        assign pkt_all[c]          = pkt_q;
        assign byte_all[c]         = byte_q;
        assign errp_all[c]         = errp_q;
    end

    assign any_err = |err_flags;

    // Out-of-range selections match no channel and read back as zero.
    always_comb begin
        pkt_cnt     = '0;
        byte_cnt    = '0;
        err_pkt_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                pkt_cnt     = pkt_all[i];
                byte_cnt    = byte_all[i];
                err_pkt_cnt = errp_all[i];
            end
        end
    end

endmodule
